// File: rtl/acorn_state_engine.sv
// ACORN-128 state-update engine: advances the 293-bit state W steps per accepted
// beat and returns the W data/keystream bits through a one-deep output register.
module acorn_state_engine #(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [292:0]     state_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_ca,
  input  logic             in_cb,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [292:0]     state_out,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam logic [1:0] MODE_DECRYPT   = 2'd2;
  localparam logic [1:0] MODE_KEYSTREAM = 2'd3;

  logic         accept;
  logic [292:0] beat_state;
  logic [W-1:0] beat_out;
  logic [293:0] step_res;

  // One ACORN step; result is {output bit, next state}.
  function automatic logic [293:0] acorn_step(
    input logic [292:0] s,
    input logic         ca,
    input logic         cb,
    input logic         d,
    input logic [1:0]   mode
  );
    logic [292:0] fb;
    logic         ks;
    logic         f;
    logic         m;
    logic         ob;
    fb      = s;
    fb[288] = s[288] ^ s[235] ^ s[230];
    fb[230] = s[230] ^ s[196] ^ s[193];
    fb[193] = s[193] ^ s[160] ^ s[154];
    fb[154] = s[154] ^ s[111] ^ s[107];
    fb[107] = s[107] ^ s[66]  ^ s[61];
    fb[61]  = s[61]  ^ s[23]  ^ s[0];
    ks = fb[12] ^ fb[154]
       ^ ((fb[235] & fb[61]) ^ (fb[235] & fb[193]) ^ (fb[61] & fb[193]))
       ^ ((fb[230] & fb[111]) ^ (~fb[230] & fb[66]));
    f  = fb[0] ^ ~fb[107]
       ^ ((fb[244] & fb[23]) ^ (fb[244] & fb[160]) ^ (fb[23] & fb[160]))
       ^ (ca & fb[196]) ^ (cb & ks);
    case (mode)
      MODE_DECRYPT:   m = d ^ ks;
      MODE_KEYSTREAM: m = 1'b0;
      default:        m = d;
    endcase
    ob = (mode == MODE_KEYSTREAM) ? ks : (d ^ ks);
    return {ob, f ^ m, fb[292:1]};
  endfunction

  assign in_ready = !load && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Unrolled chain of W steps; bit 0 of the beat is consumed first.
  always_comb begin
    beat_state = state_out;
    beat_out   = '0;
    step_res   = '0;
    for (int i = 0; i < W; i++) begin
      step_res    = acorn_step(beat_state, in_ca, in_cb, in_data[i], in_mode);
      beat_out[i] = step_res[293];
      beat_state  = step_res[292:0];
    end
  end

  // Load wins over beats; a pending output is dropped when a new state is loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_out <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      beat_cnt  <= '0;
    end else if (load) begin
      state_out <= state_in;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      state_out <= beat_state;
      out_data  <= beat_out;
      out_valid <= 1'b1;
      beat_cnt  <= beat_cnt + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acorn_state_engine.sv
// Bench for acorn_state_engine: a W=8 instance and a W=1/CNT_W=4 instance driven
// with directed and random beats, checked against a bit-level reference model.
module tb_acorn_state_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_load, a_in_valid, a_in_ready, a_ca, a_cb, a_out_valid, a_out_ready;
  logic [292:0] a_state_in, a_state_out;
  logic [7:0]   a_in_data, a_out_data;
  logic [1:0]   a_mode;
  logic [15:0]  a_beat_cnt;

  logic         b_load, b_in_valid, b_in_ready, b_ca, b_cb, b_out_valid, b_out_ready;
  logic [292:0] b_state_in, b_state_out;
  logic [0:0]   b_in_data, b_out_data;
  logic [1:0]   b_mode;
  logic [3:0]   b_beat_cnt;

  acorn_state_engine #(.W(8), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .load(a_load), .state_in(a_state_in),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .in_ca(a_ca), .in_cb(a_cb), .in_mode(a_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .state_out(a_state_out),
    .beat_cnt(a_beat_cnt)
  );

  acorn_state_engine #(.W(1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(b_load), .state_in(b_state_in),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .in_ca(b_ca), .in_cb(b_cb), .in_mode(b_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .state_out(b_state_out),
    .beat_cnt(b_beat_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model per instance: index 0 is the W=8 engine, index 1 the W=1 engine.
  logic [292:0] m_st[2];
  int           m_cnt[2];
  bit           m_vld[2];
  logic [7:0]   m_od[2];
  int           m_w[2]   = '{8, 1};
  int           m_mod[2] = '{65536, 16};

  task automatic check_output(input string tag, input logic [292:0] obs, input logic [292:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit maj(input bit x, input bit y, input bit z);
    return (int'(x) + int'(y) + int'(z)) >= 2;
  endfunction

  function automatic void model_step(input logic [292:0] s, input bit ca, input bit cb,
                                     input bit d, input logic [1:0] md,
                                     output logic [292:0] ns, output bit ob);
    bit t[293];
    bit ks, f, mb;
    for (int i = 0; i < 293; i++) t[i] = s[i];
    t[288] = s[288] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    ks = t[12] ^ t[154] ^ maj(t[235], t[61], t[193]) ^ (t[230] ? t[111] : t[66]);
    f  = t[0] ^ !t[107] ^ maj(t[244], t[23], t[160]) ^ (ca & t[196]) ^ (cb & ks);
    if (md == 2'd3)      mb = 1'b0;
    else if (md == 2'd2) mb = d ^ ks;
    else                 mb = d;
    ob = (md == 2'd3) ? ks : (d ^ ks);
    for (int i = 0; i < 292; i++) ns[i] = t[i+1];
    ns[292] = f ^ mb;
  endfunction

  function automatic void model_beat(input logic [292:0] s, input int w, input logic [7:0] d,
                                     input bit ca, input bit cb, input logic [1:0] md,
                                     output logic [292:0] ns, output logic [7:0] o);
    logic [292:0] cur, nxt;
    bit ob;
    cur = s;
    o = '0;
    for (int i = 0; i < w; i++) begin
      model_step(cur, ca, cb, d[i], md, nxt, ob);
      o[i] = ob;
      cur = nxt;
    end
    ns = cur;
  endfunction

  function automatic bit model_ready(input int k, input bit ld, input bit ordy);
    return !ld && (!m_vld[k] || ordy);
  endfunction

  task automatic model_cycle(input int k, input bit ld, input logic [292:0] sin, input bit iv,
                             input logic [7:0] d, input bit ca, input bit cb,
                             input logic [1:0] md, input bit ordy);
    logic [292:0] ns;
    logic [7:0]   o;
    bit rdy;
    rdy = model_ready(k, ld, ordy);
    if (ld) begin
      m_st[k] = sin; m_cnt[k] = 0; m_vld[k] = 0;
    end else if (iv && rdy) begin
      model_beat(m_st[k], m_w[k], d, ca, cb, md, ns, o);
      m_st[k] = ns; m_od[k] = o; m_vld[k] = 1;
      m_cnt[k] = (m_cnt[k] + 1) % m_mod[k];
    end else if (m_vld[k] && ordy) begin
      m_vld[k] = 0;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = '0; m_cnt[k] = 0; m_vld[k] = 0; m_od[k] = '0;
    end
  endtask

  function automatic logic [292:0] rand_state();
    logic [292:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r = (r << 32) | 293'($urandom);
    return r;
  endfunction

  task automatic idle_inputs();
    a_load = 0; a_state_in = '0; a_in_valid = 0; a_in_data = '0; a_ca = 0; a_cb = 0;
    a_mode = 2'd0; a_out_ready = 1;
    b_load = 0; b_state_in = '0; b_in_valid = 0; b_in_data = '0; b_ca = 0; b_cb = 0;
    b_mode = 2'd0; b_out_ready = 1;
  endtask

  // Inputs are set by the caller away from the edge; outputs are checked 1ns after it.
  task automatic step_cycle();
    #1;
    check_output("a_in_ready", a_in_ready, model_ready(0, a_load, a_out_ready));
    check_output("b_in_ready", b_in_ready, model_ready(1, b_load, b_out_ready));
    @(posedge clk);
    model_cycle(0, a_load, a_state_in, a_in_valid, a_in_data, a_ca, a_cb, a_mode, a_out_ready);
    model_cycle(1, b_load, b_state_in, b_in_valid, {7'b0, b_in_data}, b_ca, b_cb, b_mode, b_out_ready);
    #1;
    check_output("a_out_valid", a_out_valid, m_vld[0]);
    check_output("a_out_data",  a_out_data,  m_od[0]);
    check_output("a_state_out", a_state_out, m_st[0]);
    check_output("a_beat_cnt",  a_beat_cnt,  m_cnt[0]);
    check_output("b_out_valid", b_out_valid, m_vld[1]);
    check_output("b_out_data",  b_out_data,  m_od[1][0]);
    check_output("b_state_out", b_state_out, m_st[1]);
    check_output("b_beat_cnt",  b_beat_cnt,  m_cnt[1]);
  endtask

  logic [292:0] x, es, es2, exp_final;
  logic [63:0]  got_a, got_b, exp_s;
  logic [7:0]   gdata[8], pt[16], ct[16];
  logic [1:0]   gmode[8];
  bit           gca[8], gcb[8], tca[16], tcb[16], ob;
  logic [7:0]   held_data;
  int           cnt_before;

  initial begin
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("rst_a_state", a_state_out, '0);
    check_output("rst_a_valid", a_out_valid, 1'b0);
    check_output("rst_a_data",  a_out_data,  '0);
    check_output("rst_a_cnt",   a_beat_cnt,  '0);
    check_output("rst_a_ready", a_in_ready,  1'b1);
    check_output("rst_b_ready", b_in_ready,  1'b1);

    // Single W=1 step from the all-zero state.
    b_load = 1; b_state_in = '0; step_cycle(); idle_inputs();
    b_in_valid = 1; b_in_data = 1'b0; b_mode = 2'd0; step_cycle(); idle_inputs();
    check_output("t1_state", b_state_out, 293'(1) << 292);
    check_output("t1_data",  b_out_data,  1'b0);
    check_output("t1_cnt",   b_beat_cnt,  4'd1);

    // Same 64 bits through W=8 and W=1 from one random state.
    x = rand_state();
    a_load = 1; a_state_in = x; b_load = 1; b_state_in = x; step_cycle(); idle_inputs();
    for (int g = 0; g < 8; g++) begin
      gdata[g] = 8'($urandom); gmode[g] = 2'($urandom_range(0, 3));
      gca[g] = 1'($urandom); gcb[g] = 1'($urandom);
    end
    es = x;
    for (int i = 0; i < 64; i++) begin
      model_step(es, gca[i/8], gcb[i/8], gdata[i/8][i%8], gmode[i/8], es2, ob);
      exp_s[i] = ob; es = es2;
    end
    for (int i = 0; i < 64; i++) begin
      b_in_valid = 1; b_in_data = gdata[i/8][i%8]; b_ca = gca[i/8]; b_cb = gcb[i/8]; b_mode = gmode[i/8];
      a_in_valid = (i % 8 == 0); a_in_data = gdata[i/8]; a_ca = gca[i/8]; a_cb = gcb[i/8]; a_mode = gmode[i/8];
      step_cycle();
      got_b[i] = b_out_data[0];
      if (i % 8 == 0) for (int j = 0; j < 8; j++) got_a[i+j] = a_out_data[j];
    end
    idle_inputs();
    check_output("t2_a_stream", got_a, exp_s);
    check_output("t2_b_stream", got_b, exp_s);
    check_output("t2_a_state", a_state_out, es);
    check_output("t2_b_state", b_state_out, es);

    // Encrypt then decrypt 128 bits from the same state.
    x = rand_state();
    a_load = 1; a_state_in = x; step_cycle(); idle_inputs();
    for (int g = 0; g < 16; g++) begin
      pt[g] = 8'($urandom); tca[g] = 1'($urandom); tcb[g] = 1'($urandom);
      a_in_valid = 1; a_in_data = pt[g]; a_ca = tca[g]; a_cb = tcb[g]; a_mode = 2'd1;
      step_cycle();
      ct[g] = a_out_data;
    end
    idle_inputs();
    exp_final = m_st[0];
    a_load = 1; a_state_in = x; step_cycle(); idle_inputs();
    for (int g = 0; g < 16; g++) begin
      a_in_valid = 1; a_in_data = ct[g]; a_ca = tca[g]; a_cb = tcb[g]; a_mode = 2'd2;
      step_cycle();
      check_output("t3_plain", a_out_data, pt[g]);
    end
    idle_inputs();
    check_output("t3_state", a_state_out, exp_final);

    // Backpressure: output held while the consumer stalls, then full throughput.
    a_in_valid = 1; a_in_data = 8'($urandom); a_mode = 2'd1; step_cycle();
    held_data = m_od[0]; cnt_before = m_cnt[0]; es = m_st[0];
    a_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      a_in_data = 8'($urandom); step_cycle();
      check_output("t4_ready_low", a_in_ready, 1'b0);
      check_output("t4_held_data", a_out_data, held_data);
      check_output("t4_held_state", a_state_out, es);
      check_output("t4_held_cnt", a_beat_cnt, 16'(cnt_before));
    end
    a_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      a_in_data = 8'($urandom); a_mode = 2'($urandom_range(0, 3)); step_cycle();
    end
    check_output("t4_cnt", a_beat_cnt, 16'(cnt_before + 6));

    // Load while a beat is offered and an output is pending.
    a_out_ready = 0; a_in_data = 8'($urandom); step_cycle();
    x = rand_state();
    a_load = 1; a_state_in = x; a_in_valid = 1;
    #1; check_output("t5_ready", a_in_ready, 1'b0);
    step_cycle(); idle_inputs();
    check_output("t5_state", a_state_out, x);
    check_output("t5_valid", a_out_valid, 1'b0);
    check_output("t5_cnt",   a_beat_cnt,  '0);

    // Random traffic on both engines.
    for (int i = 0; i < 300; i++) begin
      a_load = ($urandom_range(0, 31) == 0); a_state_in = rand_state();
      a_in_valid = ($urandom_range(0, 3) != 0); a_in_data = 8'($urandom);
      a_ca = 1'($urandom); a_cb = 1'($urandom); a_mode = 2'($urandom_range(0, 3));
      a_out_ready = ($urandom_range(0, 2) != 0);
      b_load = ($urandom_range(0, 31) == 0); b_state_in = rand_state();
      b_in_valid = ($urandom_range(0, 3) != 0); b_in_data = 1'($urandom);
      b_ca = 1'($urandom); b_cb = 1'($urandom); b_mode = 2'($urandom_range(0, 3));
      b_out_ready = ($urandom_range(0, 2) != 0);
      step_cycle();
    end
    idle_inputs();

    // Counter wrap on the 4-bit instance.
    b_load = 1; b_state_in = '0; step_cycle(); idle_inputs();
    for (int i = 0; i < 17; i++) begin
      b_in_valid = 1; b_in_data = 1'($urandom); b_mode = 2'($urandom_range(0, 3)); step_cycle();
    end
    idle_inputs();
    check_output("t6_wrap", b_beat_cnt, 4'd1);

    // Asynchronous reset between clock edges.
    a_in_valid = 1; a_in_data = 8'($urandom); b_in_valid = 1; b_in_data = 1'b1; step_cycle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_output("arst_a_state", a_state_out, '0);
    check_output("arst_a_valid", a_out_valid, 1'b0);
    check_output("arst_a_data",  a_out_data,  '0);
    check_output("arst_a_cnt",   a_beat_cnt,  '0);
    check_output("arst_b_state", b_state_out, '0);
    check_output("arst_b_valid", b_out_valid, 1'b0);
    check_output("arst_b_cnt",   b_beat_cnt,  '0);
    @(negedge clk) rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      b_in_valid = 1; b_in_data = 1'($urandom); a_in_valid = 1; a_in_data = 8'($urandom);
      step_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
